mem_rd_ctr_a: RTL and testbench



---
 rtl/mem_rd_ctr_a.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_rd_ctr_a.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_ctr_a.sv
// mem_rd_ctr_a
// Read-side controller for frame buffer BRAM A. A start pulse reads one
// MAX_ROW x MAX_COL frame sequentially through BRAM port B. Each read is
// tracked through the BRAM latency and collected in a small output FIFO.
// Pixels leave on a valid/ready stream carrying frame and line markers.
// Reads are limited by credits, so backpressure never drops a pixel.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         1-cycle pulse, frame in BRAM A complete (honoured in IDLE)
//   enb_o, web_o    BRAM port-B enable / write enable (web_o tied 0)
//   addrb_o         BRAM port-B address (19 bits)
//   d2memb_o        BRAM port-B write data (tied 0)
//   mem2db_i        BRAM port-B read data, RD_LAT cycles after enb_o
//   pixel_o         output pixel, qualified by pixel_valid_o
//   pixel_valid_o   output FIFO non-empty
//   pixel_ready_i   downstream accepts
//   sof_o/eol_o/eof_o  first pixel of frame / last of row / last of frame
//   busy_o          frame readout in progress
//   done_o          1-cycle pulse, last pixel of the frame delivered
module mem_rd_ctr_a #(
    parameter int unsigned MAX_ROW    = 540,
    parameter int unsigned MAX_COL    = 540,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = RD_LAT + 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        enb_o,
    output logic        web_o,
    output logic [18:0] addrb_o,
    output logic [7:0]  d2memb_o,
    input  logic [7:0]  mem2db_i,
    output logic [7:0]  pixel_o,
    output logic        pixel_valid_o,
    input  logic        pixel_ready_i,
    output logic        sof_o,
    output logic        eol_o,
    output logic        eof_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned NPIX   = MAX_ROW * MAX_COL;
    localparam int unsigned ROW_W  = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam int unsigned COL_W  = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W  = $clog2(RD_LAT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(MAX_ROW - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(MAX_COL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [RD_LAT-1:0]   tag_q, tag_d;
    logic [INF_W-1:0]    inflight_d;
    logic [PIX_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;

    logic                push;
    logic                pop;
    logic                enb_d;
    logic [ADDR_W-1:0]   addrb_d;
    logic [PIX_W-1:0]    pixel_d;
    logic                valid_d;
    logic                sof_d;
    logic                eol_d;
    logic                eof_d;
    logic                busy_d;
    logic                done_d;

    assign web_o    = 1'b0;
    assign d2memb_o = '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, issue, FIFO bookkeeping and output marker logic.
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        tag_d      = '0;
        inflight_d = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        enb_d      = 1'b0;
        addrb_d    = addrb_o;
        pixel_d    = '0;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        eof_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        // The oldest tag marks the cycle whose mem2db_i belongs to a read.
        push = tag_q[RD_LAT-1];
        pop  = pixel_valid_o & pixel_ready_i;

        case (state_q)
            S_IDLE:  if (start_i) state_d = S_READ;
            S_READ:  if (enb_o && (addrb_o == LAST_ADDR)) state_d = S_DRAIN;
            S_DRAIN: if (pop && eof_o) state_d = S_DONE;
            S_DONE: begin
                state_d    = S_IDLE;
                addr_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // In-flight tag shift register: bit i set means a read issued i+1 cycles ago.
        tag_d[0] = enb_o;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_d = inflight_d + INF_W'(tag_d[i]);
        end

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end

        // Issue for next cycle only if every outstanding read still has a FIFO slot.
        // Built from register next-values, so enb_o itself stays a flop.
        if ((state_d == S_READ) && ((32'(fifo_cnt_d) + 32'(inflight_d)) < FIFO_DEPTH)) begin
            enb_d      = 1'b1;
            addrb_d    = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        end

        // Output position counters advance per accepted pixel.
        if (state_q == S_DONE) begin
            row_d = '0;
            col_d = '0;
        end else if (pop) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Registered head of FIFO; bypass the write when the pushed entry becomes the head.
        valid_d = (fifo_cnt_d != '0);
        if (valid_d) begin
            pixel_d = (push && (wr_ptr_q == rd_ptr_d)) ? mem2db_i : fifo_mem[rd_ptr_d];
        end
        sof_d  = valid_d && (row_d == '0) && (col_d == '0);
        eol_d  = valid_d && (col_d == LAST_COL);
        eof_d  = valid_d && (col_d == LAST_COL) && (row_d == LAST_ROW);
        busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_cnt_q    <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            row_q         <= '0;
            col_q         <= '0;
            enb_o         <= 1'b0;
            addrb_o       <= '0;
            pixel_o       <= '0;
            pixel_valid_o <= 1'b0;
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            eof_o         <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_cnt_q    <= addr_cnt_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            enb_o         <= enb_d;
            addrb_o       <= addrb_d;
            pixel_o       <= pixel_d;
            pixel_valid_o <= valid_d;
            sof_o         <= sof_d;
            eol_o         <= eol_d;
            eof_o         <= eof_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
        end
    end

    // FIFO storage; contents are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem2db_i;
    end

endmodule

// File: tb/tb_mem_rd_ctr_a.sv
// Bench for mem_rd_ctr_a: a 4x4 instance (RD_LAT=2) for streaming, stall,
// random backpressure, start handling and reset, plus a 3x540 instance
// (RD_LAT=3) for wide rows and deeper latency.
module tb_mem_rd_ctr_a;

    localparam int unsigned R = 4, C = 4, LAT = 2, DEP = LAT + 2, N = R * C;
    localparam int unsigned BR = 3, BC = 540, BLAT = 3, BDEP = BLAT + 2, BN = BR * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_a, enb_a, web_a, val_a, rdy_a, sof_a, eol_a, eof_a, busy_a, done_a;
    logic [18:0] addr_a;
    logic [7:0]  d2m_a, m2d_a, pix_a;
    logic        start_b, enb_b, web_b, val_b, rdy_b, sof_b, eol_b, eof_b, busy_b, done_b;
    logic [18:0] addr_b;
    logic [7:0]  d2m_b, m2d_b, pix_b;

    int n_vec = 0;
    int n_err = 0;

    mem_rd_ctr_a #(.MAX_ROW(R), .MAX_COL(C), .RD_LAT(LAT), .FIFO_DEPTH(DEP)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .enb_o(enb_a), .web_o(web_a),
        .addrb_o(addr_a), .d2memb_o(d2m_a), .mem2db_i(m2d_a), .pixel_o(pix_a),
        .pixel_valid_o(val_a), .pixel_ready_i(rdy_a), .sof_o(sof_a), .eol_o(eol_a),
        .eof_o(eof_a), .busy_o(busy_a), .done_o(done_a));

    mem_rd_ctr_a #(.MAX_ROW(BR), .MAX_COL(BC), .RD_LAT(BLAT), .FIFO_DEPTH(BDEP)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .enb_o(enb_b), .web_o(web_b),
        .addrb_o(addr_b), .d2memb_o(d2m_b), .mem2db_i(m2d_b), .pixel_o(pix_b),
        .pixel_valid_o(val_b), .pixel_ready_i(rdy_b), .sof_o(sof_b), .eol_o(eol_b),
        .eof_o(eof_b), .busy_o(busy_b), .done_o(done_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // BRAM models: data = addr[7:0] exactly RD_LAT cycles after the read; junk otherwise.
    logic [7:0] pipe_a [LAT];
    logic [7:0] pipe_b [BLAT];
    always @(posedge clk) begin
        pipe_a[0] <= enb_a ? addr_a[7:0] : 8'hEE;
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= enb_b ? addr_b[7:0] : 8'hEE;
        for (int i = 1; i < BLAT; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign m2d_a = pipe_a[LAT-1];
    assign m2d_b = pipe_b[BLAT-1];

    // Reference model A: frame position k, issue index, totals, handshake hold.
    bit         act_a, dexp_a, stall_a;
    int         iss_a, k_a, iss_tot_a, xf_tot_a;
    logic [10:0] prev_a;
    always @(negedge clk) begin
        bit dn;
        if (!rst_n) begin
            act_a = 0; dexp_a = 0; stall_a = 0;
            iss_a = 0; k_a = 0; iss_tot_a = 0; xf_tot_a = 0; prev_a = '0;
        end else begin
            chk("a_done", done_a, dexp_a);
            chk("a_busy", busy_a, act_a);
            chk("a_wport", {web_a, d2m_a}, 0);
            if (enb_a) begin
                chk("a_issue_in_frame", act_a, 1);
                chk("a_addr_range", iss_a < N, 1);
                chk("a_addr", addr_a, iss_a);
                iss_a++; iss_tot_a++;
            end
            chk("a_credit", (iss_tot_a - xf_tot_a) <= DEP, 1);
            if (stall_a) chk("a_hold", {val_a, pix_a, sof_a, eol_a, eof_a}, {1'b1, prev_a});
            if (val_a) begin
                chk("a_phantom", iss_tot_a > xf_tot_a, 1);
                chk("a_pixel", pix_a, k_a[7:0]);
                chk("a_markers", {sof_a, eol_a, eof_a},
                    {k_a == 0, (k_a % C) == C - 1, k_a == N - 1});
            end
            dn = 0;
            if (val_a && rdy_a) begin
                xf_tot_a++;
                if (k_a == N - 1) begin
                    dn = 1;
                    chk("a_issued_at_end", iss_a, N);
                    k_a = 0;
                end else begin
                    k_a++;
                end
            end
            if (start_a && !act_a && !dexp_a) begin
                act_a = 1; iss_a = 0; k_a = 0;
            end
            if (dn) act_a = 0;
            dexp_a  = dn;
            stall_a = val_a && !rdy_a;
            prev_a  = {pix_a, sof_a, eol_a, eof_a};
        end
    end

    // Reference model B: order, markers, range, done timing.
    bit  act_b, dexp_b;
    int  iss_b, k_b, xf_b, eofs_b;
    logic [18:0] last_addr_b;
    always @(negedge clk) begin
        bit dn;
        if (!rst_n) begin
            act_b = 0; dexp_b = 0; iss_b = 0; k_b = 0; xf_b = 0; eofs_b = 0; last_addr_b = '0;
        end else begin
            chk("b_done", done_b, dexp_b);
            chk("b_busy", busy_b, act_b);
            if (enb_b) begin
                chk("b_addr_range", iss_b < BN, 1);
                chk("b_addr", addr_b, iss_b);
                last_addr_b = addr_b;
                iss_b++;
            end
            if (val_b) begin
                chk("b_pixel", pix_b, k_b[7:0]);
                chk("b_markers", {sof_b, eol_b, eof_b},
                    {k_b == 0, (k_b % BC) == BC - 1, k_b == BN - 1});
            end
            dn = 0;
            if (val_b && rdy_b) begin
                xf_b++;
                if (eof_b) eofs_b++;
                if (k_b == BN - 1) begin dn = 1; k_b = 0; end
                else k_b++;
            end
            if (start_b && !act_b && !dexp_b) begin act_b = 1; iss_b = 0; k_b = 0; end
            if (dn) act_b = 0;
            dexp_b = dn;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optionally pulse start, then run until done_a or budget expires.
    task automatic frame_a(input bit do_start, input bit rnd, input int budget, output int nd);
        nd = 0;
        start_a = do_start;
        for (int c = 0; c < budget; c++) begin
            if (rnd) rdy_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_a) nd++;
            tick();
            start_a = 1'b0;
            if (nd != 0) break;
        end
    endtask

    initial begin
        int f_enb, l_enb, f_val, l_val, d_cyc, n_done, cnt, nd;
        rst_n = 1'b0; start_a = 1'b0; rdy_a = 1'b1; start_b = 1'b0; rdy_b = 1'b1;

        @(negedge clk);
        chk("reset_a", {enb_a, addr_a, val_a, pix_a, sof_a, eol_a, eof_a, busy_a, done_a}, 0);
        chk("reset_b", {enb_b, addr_b, val_b, pix_b, busy_b, done_b}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: streaming, ready=1; start in cycle 0
        f_enb = -1; l_enb = -1; f_val = -1; l_val = -1; d_cyc = -1; n_done = 0;
        start_a = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (enb_a) begin if (f_enb < 0) f_enb = c; l_enb = c; end
            if (val_a) begin if (f_val < 0) f_val = c; l_val = c; end
            if (done_a) begin d_cyc = c; n_done++; end
            tick();
            start_a = 1'b0;
        end
        chk("t1_first_enb", f_enb, 1);
        chk("t1_last_enb", l_enb, 16);
        chk("t1_first_valid", f_val, 4);
        chk("t1_last_valid", l_val, 19);
        chk("t1_done_cycle", d_cyc, 20);
        chk("t1_done_count", n_done, 1);

        // 2: stall from start, then release
        rdy_a = 1'b0; start_a = 1'b1; cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (enb_a) cnt++;
            tick();
            start_a = 1'b0;
        end
        chk("t2_reads_stalled", cnt, 4);
        @(negedge clk);
        chk("t2_head", {val_a, sof_a, pix_a}, {1'b1, 1'b1, 8'h00});
        tick();
        rdy_a = 1'b1;
        frame_a(1'b0, 1'b0, 60, nd);
        chk("t2_done", nd, 1);

        // 3: random ready over many frames
        for (int f = 0; f < 300; f++) begin
            frame_a(1'b1, 1'b1, 400, nd);
            if (nd != 1) chk("t3_done", nd, 1);
            else n_vec++;
        end
        rdy_a = 1'b1;
        tick();

        // 4: start mid-READ ignored, start after done restarts at 0
        start_a = 1'b1;
        repeat (5) begin @(negedge clk); tick(); start_a = 1'b0; end
        start_a = 1'b1;
        @(negedge clk);
        tick();
        start_a = 1'b0;
        @(negedge clk);
        chk("t4_busy_mid", busy_a, 1);
        frame_a(1'b0, 1'b0, 60, nd);
        chk("t4_done_first", nd, 1);
        start_a = 1'b1;
        @(negedge clk);
        tick();
        start_a = 1'b0;
        @(negedge clk);
        chk("t4_restart", {enb_a, addr_a}, {1'b1, 19'd0});
        frame_a(1'b0, 1'b0, 60, nd);
        chk("t4_done_second", nd, 1);

        // 5: asynchronous reset mid-frame
        start_a = 1'b1;
        repeat (8) begin @(negedge clk); tick(); start_a = 1'b0; end
        chk("t5_active_before", {busy_a, val_a}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_zero", {enb_a, addr_a, val_a, pix_a, sof_a, eol_a, eof_a, busy_a, done_a}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frame_a(1'b1, 1'b0, 60, nd);
        chk("t5_clean_frame", nd, 1);

        // 6: wide rows, deeper latency, periodic stalls
        nd = 0;
        start_b = 1'b1;
        for (int c = 0; c < 4000 && nd == 0; c++) begin
            rdy_b = ((c % 7) != 3);
            @(negedge clk);
            if (done_b) nd++;
            tick();
            start_b = 1'b0;
        end
        repeat (5) begin @(negedge clk); if (done_b) nd++; tick(); end
        chk("t6_done_count", nd, 1);
        chk("t6_last_addr", last_addr_b, 1619);
        chk("t6_transfers", xf_b, 1620);
        chk("t6_eof_count", eofs_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
